// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer and flush
// Optional backpressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid #(
   parameter int WIDTH = 32,
   parameter int NCH   = 2
`ifdef PIPE_STALL_CNT_EN
  ,parameter int CNT_W = 16
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [1:0]             occupancy
`ifdef PIPE_STALL_CNT_EN
  ,output logic [CNT_W-1:0]       stall_cnt
`endif
);

   localparam int DW = NCH * WIDTH;

   logic          m_v_q, m_v_d;
   logic          s_v_q, s_v_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic [DW-1:0] s_data_q, s_data_d;
   logic          in_ready_q;
   logic [1:0]    occ_q;
   logic          in_fire;

   assign in_fire = in_valid & in_ready_q;

   always_comb begin
      m_v_d    = m_v_q;
      s_v_d    = s_v_q;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
      if (flush) begin
         // Data registers keep stale contents; only the valid bits are squashed.
         m_v_d = 1'b0;
         s_v_d = 1'b0;
      end else if (!m_v_q || out_ready) begin
         if (s_v_q) begin
            m_data_d = s_data_q;
            m_v_d    = 1'b1;
            if (in_fire) begin
               s_data_d = in_data;
            end else begin
               s_v_d = 1'b0;
            end
         end else if (in_fire) begin
            m_data_d = in_data;
            m_v_d    = 1'b1;
         end else begin
            m_v_d = 1'b0;
         end
      end else if (in_fire) begin
         s_data_d = in_data;
         s_v_d    = 1'b1;
      end
   end

   // in_ready and occupancy are registered from next-state so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_v_q      <= 1'b0;
         s_v_q      <= 1'b0;
         m_data_q   <= '0;
         s_data_q   <= '0;
         in_ready_q <= 1'b1;
         occ_q      <= 2'd0;
      end else begin
         m_v_q      <= m_v_d;
         s_v_q      <= s_v_d;
         m_data_q   <= m_data_d;
         s_data_q   <= s_data_d;
         in_ready_q <= !s_v_d;
         occ_q      <= {1'b0, m_v_d} + {1'b0, s_v_d};
      end
   end

   assign out_valid = m_v_q;
   assign out_data  = m_data_q;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   // Saturating count of cycles the head entry waits on downstream; flush leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (m_v_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
